// File: rtl/clock_time_ctrl.sv
// Sequencing controller for the HH:MM:SS BCD counter bank: counting, time/alarm set, alarm ring.
// Latency: counter strobes are combinational in the strobe cycle; mode/blink/alarm state updates on that edge.
// Backpressure: none; every pulse is acted on in its own cycle (btn_mode wins over btn_inc).
module clock_time_ctrl #(
    parameter int TICK_HOLD = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        alarm_en,
    input  logic [23:0] digit_in,
    input  logic [5:0]  flag_in,
    output logic [5:0]  cnt_en,
    output logic [5:0]  load_en,
    output logic [23:0] load_num,
    output logic [2:0]  mode,
    output logic [5:0]  blink,
    output logic [15:0] alarm_hhmm,
    output logic        alarm_ring
);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        SET_HR     = 3'd1,
        SET_MIN    = 3'd2,
        SET_SEC    = 3'd3,
        SET_AL_HR  = 3'd4,
        SET_AL_MIN = 3'd5
    } mode_e;

    // Two-digit BCD field to binary (fields are always valid BCD, max 99)
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Increment a BCD field as a whole, wrapping to 00 past 'top'
    function automatic logic [7:0] bcd_inc(input logic [7:0] b, input logic [6:0] top);
        logic [6:0] v;
        v = bcd_to_bin(b);
        return bin_to_bcd((v >= top) ? 7'd0 : v + 7'd1);
    endfunction

    function automatic logic [5:0] blink_of(input mode_e m);
        case (m)
            SET_HR, SET_AL_HR:   return 6'b110000;
            SET_MIN, SET_AL_MIN: return 6'b001100;
            SET_SEC:             return 6'b000011;
            default:             return 6'b000000;
        endcase
    endfunction

    mode_e       mode_q, mode_d;
    logic [5:0]  blink_q;
    logic [15:0] alarm_q, alarm_d;
    logic        match_q;
    logic        ring_q, ring_d;
    logic [5:0]  tick_cnt_q, tick_cnt_d;

    logic [5:0]  cnt_en_c, load_en_c;
    logic [23:0] load_num_c;

    logic inc_req;
    logic hr_wrap;
    logic match;
    logic hold_done;
    logic ring_set;
    logic ring_clr;

    // btn_mode has priority, so an increment only counts when it arrives alone
    assign inc_req = btn_inc & ~btn_mode;

    // 23:59:59: tens-of-hours at its max, ones-of-hours at 3, and everything below at max
    assign hr_wrap = flag_in[5] & (digit_in[19:16] == 4'd3) & (&flag_in[3:0]);

    assign match = (digit_in == {alarm_q, 8'h00});

    // Counter strobes: ripple carry while running, whole-field loads while setting
    always_comb begin
        cnt_en_c   = '0;
        load_en_c  = '0;
        load_num_c = '0;
        case (mode_q)
            RUN: begin
                if (tick) begin
                    if (hr_wrap) begin
                        cnt_en_c  = '1;
                        load_en_c = '1;
                    end else begin
                        cnt_en_c[0] = 1'b1;
                        for (int i = 1; i < 6; i++) begin
                            cnt_en_c[i] = cnt_en_c[i-1] & flag_in[i-1];
                        end
                    end
                end
            end
            SET_HR: begin
                if (inc_req) begin
                    cnt_en_c[5:4]     = 2'b11;
                    load_en_c[5:4]    = 2'b11;
                    load_num_c[23:16] = bcd_inc(digit_in[23:16], 7'd23);
                end
            end
            SET_MIN: begin
                if (inc_req) begin
                    cnt_en_c[3:2]    = 2'b11;
                    load_en_c[3:2]   = 2'b11;
                    load_num_c[15:8] = bcd_inc(digit_in[15:8], 7'd59);
                end
            end
            SET_SEC: begin
                if (inc_req) begin
                    cnt_en_c[1:0]  = 2'b11;
                    load_en_c[1:0] = 2'b11;
                end
            end
            default: ;
        endcase
    end

    // Nothing reaches the counters while this block is held in reset
    assign cnt_en   = rst_n ? cnt_en_c   : '0;
    assign load_en  = rst_n ? load_en_c  : '0;
    assign load_num = rst_n ? load_num_c : '0;

    // Mode advance; a press while ringing only dismisses the alarm
    always_comb begin
        mode_d = mode_q;
        if (btn_mode && !ring_q) begin
            case (mode_q)
                RUN:       mode_d = SET_HR;
                SET_HR:    mode_d = SET_MIN;
                SET_MIN:   mode_d = SET_SEC;
                SET_SEC:   mode_d = SET_AL_HR;
                SET_AL_HR: mode_d = SET_AL_MIN;
                default:   mode_d = RUN;
            endcase
        end
    end

    // Mode register with blink registered alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= RUN;
            blink_q <= '0;
        end else begin
            mode_q  <= mode_d;
            blink_q <= blink_of(mode_d);
        end
    end

    // Alarm time editing and ring set/clear decisions (clear beats set)
    always_comb begin
        alarm_d = alarm_q;
        if (inc_req && mode_q == SET_AL_HR) begin
            alarm_d[15:8] = bcd_inc(alarm_q[15:8], 7'd23);
        end
        if (inc_req && mode_q == SET_AL_MIN) begin
            alarm_d[7:0] = bcd_inc(alarm_q[7:0], 7'd59);
        end

        hold_done = ring_q & tick & (tick_cnt_q == 6'(TICK_HOLD - 1));
        ring_clr  = btn_mode | btn_inc | ~alarm_en | hold_done;
        ring_set  = (mode_q == RUN) & alarm_en & match & ~match_q;

        ring_d = ring_q;
        if (ring_clr) begin
            ring_d = 1'b0;
        end else if (ring_set) begin
            ring_d = 1'b1;
        end

        tick_cnt_d = tick_cnt_q;
        if (ring_set) begin
            tick_cnt_d = '0;
        end else if (ring_q && tick) begin
            tick_cnt_d = tick_cnt_q + 6'd1;
        end
    end

    // Alarm state; match_q resets high so a 00:00:00 display after reset cannot ring
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q    <= '0;
            match_q    <= 1'b1;
            ring_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            alarm_q    <= alarm_d;
            match_q    <= match;
            ring_q     <= ring_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign mode       = mode_q;
    assign blink      = blink_q;
    assign alarm_hhmm = alarm_q;
    assign alarm_ring = ring_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Randomized + directed bench for clock_time_ctrl with a queue-based scoreboard.
// The counter bank is modelled as a seconds-of-day integer driving digit_in/flag_in.
// Expected outputs per cycle are queued by the driver and popped by an independent monitor.
module tb_clock_time_ctrl;

    localparam int TICK_HOLD = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        btn_mode;
    logic        btn_inc;
    logic        alarm_en;
    logic [23:0] digit_in;
    logic [5:0]  flag_in;
    logic [5:0]  cnt_en;
    logic [5:0]  load_en;
    logic [23:0] load_num;
    logic [2:0]  mode;
    logic [5:0]  blink;
    logic [15:0] alarm_hhmm;
    logic        alarm_ring;

    always #5 clk = ~clk;

    clock_time_ctrl #(.TICK_HOLD(TICK_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .alarm_en   (alarm_en),
        .digit_in   (digit_in),
        .flag_in    (flag_in),
        .cnt_en     (cnt_en),
        .load_en    (load_en),
        .load_num   (load_num),
        .mode       (mode),
        .blink      (blink),
        .alarm_hhmm (alarm_hhmm),
        .alarm_ring (alarm_ring)
    );

    typedef struct {
        logic [5:0]  cnt_en;
        logic [5:0]  load_en;
        logic [23:0] load_num;
        logic [2:0]  mode;
        logic [5:0]  blink;
        logic [15:0] alarm;
        logic        ring;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state (time as seconds of the day)
    int m_time;
    int m_mode;
    int m_al_h;
    int m_al_m;
    int m_ticks;
    bit m_ring;
    bit m_prev_match;
    bit rst_drive;
    bit aen;

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [23:0] time_bcd(input int t);
        return {bcd(t / 3600), bcd((t / 60) % 60), bcd(t % 60)};
    endfunction

    function automatic logic [5:0] flags_of(input logic [23:0] d);
        logic [5:0] f;
        f[5] = (d[23:20] >= 4'd2);
        f[4] = (d[19:16] >= 4'd9);
        f[3] = (d[15:12] >= 4'd5);
        f[2] = (d[11:8]  >= 4'd9);
        f[1] = (d[7:4]   >= 4'd5);
        f[0] = (d[3:0]   >= 4'd9);
        return f;
    endfunction

    function automatic logic [5:0] blink_of(input int m);
        case (m)
            1, 4:    return 6'b110000;
            2, 5:    return 6'b001100;
            3:       return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [23:0] expand(input logic [5:0] m);
        logic [23:0] r;
        for (int i = 0; i < 6; i++) r[4*i +: 4] = {4{m[i]}};
        return r;
    endfunction

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic model_reset();
        m_mode       = 0;
        m_al_h       = 0;
        m_al_m       = 0;
        m_ticks      = 0;
        m_ring       = 1'b0;
        m_prev_match = 1'b1;
    endtask

    // One clock of stimulus: drive at negedge, queue the expectation, advance the model
    task automatic step(input bit tk, input bit bm, input bit bi);
        exp_t        e;
        logic [23:0] now_d;
        logic [23:0] nxt_d;
        logic [5:0]  mask;
        int          nt, h, mi, s;
        bit          match, set, clr, ring_before;
        @(negedge clk);
        rst_n    = rst_drive;
        tick     = tk;
        btn_mode = bm;
        btn_inc  = bi;
        alarm_en = aen;
        now_d    = time_bcd(m_time);
        digit_in = now_d;
        flag_in  = flags_of(now_d);
        if (!rst_drive) model_reset();

        e.mode     = 3'(m_mode);
        e.blink    = blink_of(m_mode);
        e.alarm    = {bcd(m_al_h), bcd(m_al_m)};
        e.ring     = m_ring;
        e.cnt_en   = '0;
        e.load_en  = '0;
        e.load_num = '0;
        nt = m_time;

        if (rst_drive) begin
            if (m_mode == 0 && tk) begin
                // every digit that changes across the second boundary is enabled
                nt    = (m_time + 1) % 86400;
                nxt_d = time_bcd(nt);
                for (int i = 0; i < 6; i++) e.cnt_en[i] = (nxt_d[4*i +: 4] != now_d[4*i +: 4]);
                if (nt == 0) e.load_en = '1;
            end else if (bi && !bm && m_mode >= 1 && m_mode <= 3) begin
                h  = m_time / 3600;
                mi = (m_time / 60) % 60;
                s  = m_time % 60;
                mask = '0;
                case (m_mode)
                    1: begin h  = (h + 1) % 24;  mask = 6'b110000; end
                    2: begin mi = (mi + 1) % 60; mask = 6'b001100; end
                    default: begin s = 0;        mask = 6'b000011; end
                endcase
                nt         = hms(h, mi, s);
                e.cnt_en   = mask;
                e.load_en  = mask;
                e.load_num = time_bcd(nt) & expand(mask);
            end

            match = (m_time == hms(m_al_h, m_al_m, 0));
            ring_before = m_ring;
            clr = bm || bi || !aen || (m_ring && tk && (m_ticks + 1 == TICK_HOLD));
            set = (m_mode == 0) && aen && match && !m_prev_match;
            if (clr) m_ring = 1'b0;
            else if (set) begin
                m_ring  = 1'b1;
                m_ticks = 0;
            end else if (m_ring && tk) m_ticks++;

            if (bi && !bm && m_mode == 4) m_al_h = (m_al_h + 1) % 24;
            if (bi && !bm && m_mode == 5) m_al_m = (m_al_m + 1) % 60;
            if (bm && !ring_before) m_mode = (m_mode + 1) % 6;
            m_prev_match = match;
            m_time = nt;
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample mid-low-phase, pop one expectation per driven cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cnt_en",     32'(cnt_en),                        32'(e.cnt_en));
                chk("load_en",    32'(load_en),                       32'(e.load_en));
                chk("load_num",   32'(load_num & expand(e.load_en)),  32'(e.load_num));
                chk("mode",       32'(mode),                          32'(e.mode));
                chk("blink",      32'(blink),                         32'(e.blink));
                chk("alarm_hhmm", 32'(alarm_hhmm),                    32'(e.alarm));
                chk("alarm_ring", 32'(alarm_ring),                    32'(e.ring));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, k;
        rst_n = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        alarm_en = 1'b0; digit_in = '0; flag_in = '0;
        rst_drive = 1'b0; aen = 1'b0; m_time = 0;
        model_reset();
        repeat (3) step(0, 0, 0);
        rst_drive = 1'b1;

        // Midnight rollover and a natural 19:59:59 carry
        m_time = hms(23, 59, 59); step(1, 0, 0); step(0, 0, 0);
        m_time = hms(19, 59, 59); step(1, 0, 0); step(0, 0, 0);
        m_time = hms(9, 59, 59);  step(1, 0, 0); step(0, 0, 0);

        // Hour set with wrap, then frozen time
        m_time = hms(23, 15, 42);
        step(0, 1, 0); step(0, 0, 1); step(0, 0, 0);
        repeat (5) step(1, 0, 0);

        // Minute and second set, then back to RUN
        step(0, 1, 0);
        m_time = hms(10, 59, 30);
        step(0, 0, 1); step(0, 1, 0); step(0, 0, 1);
        repeat (3) step(0, 1, 0);
        step(0, 0, 0);

        // Program alarm 07:30 and let it ring for the full hold
        repeat (4) step(0, 1, 0);
        repeat (7) step(0, 0, 1);
        step(0, 1, 0);
        repeat (30) step(0, 0, 1);
        step(0, 1, 0);
        aen = 1'b1;
        m_time = hms(7, 29, 59);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        repeat (60) step(1, 0, 0);
        step(0, 0, 0); step(0, 0, 0);

        // Dismiss with btn_mode: mode must stay RUN
        m_time = hms(7, 29, 59);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 1, 0); step(0, 0, 0);

        // Simultaneous mode+inc in SET_HR
        step(0, 1, 0); step(0, 1, 1); step(0, 0, 0);
        repeat (4) step(0, 1, 0);

        // Reset mid-ring
        m_time = hms(7, 29, 59);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        rst_drive = 1'b0; step(0, 0, 0); step(0, 0, 0);
        rst_drive = 1'b1; step(0, 0, 0);

        // Reset mid-set in SET_AL_MIN, then hold 00:00:00 against alarm 00:00
        repeat (5) step(0, 1, 0);
        repeat (3) step(0, 0, 1);
        m_time = 0;
        rst_drive = 1'b0; step(0, 0, 0); step(0, 0, 0);
        rst_drive = 1'b1;
        repeat (5) step(0, 0, 0);
        repeat (3) step(1, 0, 0);

        // Randomized phase
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 999);
            if (r < 10) begin
                k = $urandom_range(0, 3);
                m_time = (hms(m_al_h, m_al_m, 0) - k + 86400) % 86400;
            end else if (r < 14) begin
                m_time = hms(23, 59, 59 - $urandom_range(0, 2));
            end else if (r < 20) begin
                m_time = $urandom_range(0, 86399);
            end else if (r < 30) begin
                aen = ~aen;
            end
            rst_drive = ($urandom_range(0, 399) != 0);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0);
        end
        rst_drive = 1'b1;
        step(0, 0, 0);

        repeat (3) @(negedge clk);
        #5;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
